// File: rtl/glyph_stream.sv
// ---------------------------------------------------------------------------
// glyph_stream
//   Renders one stored bitmap glyph as a stream of 12-bit RGB pixels over a
//   valid/ready handshake. Each source row is loaded into a shift register in
//   a one-cycle FETCH state and then shifted out MSB (leftmost) first. Every
//   bit is replicated SCALE times horizontally, and every row is emitted as
//   SCALE output lines. Each line, repeats included, gets its own FETCH.
//
// Parameters
//   GLYPH_W, GLYPH_H : glyph size in pixels / rows (2..32)
//   NUM_GLYPHS       : number of glyphs in GLYPH_DATA (>=2)
//   SCALE            : pixel replication factor in both axes (1..4)
//   GLYPH_DATA       : flat bitmap table. Glyph 0 row 0 is in the top GLYPH_W
//                      bits, rows ascend, then glyphs ascend.
//   FG_COLOR/BG_COLOR: 4:4:4 RGB colours for set and clear bits
//
// Ports
//   clk       : clock, rising edge
//   clr       : synchronous active-high reset; overrides everything
//   start     : render request. Accepted only in IDLE.
//   sel       : glyph index, latched with start. Out of range selects glyph 0.
//   inv       : swap FG/BG, latched with start
//   busy      : high in FETCH, SHIFT and FIN
//   pix_valid : pix_data/pix_eol/pix_last are valid (SHIFT state)
//   pix_ready : downstream accepts the current pixel
//   pix_data  : RGB pixel
//   pix_eol   : last pixel of an output line
//   pix_last  : last pixel of the glyph
//   done      : one-cycle completion pulse (FIN state)
// ---------------------------------------------------------------------------
module glyph_stream #(
    parameter int GLYPH_W    = 16,
    parameter int GLYPH_H    = 16,
    parameter int NUM_GLYPHS = 4,
    parameter int SCALE      = 1,
    parameter logic [NUM_GLYPHS*GLYPH_H*GLYPH_W-1:0] GLYPH_DATA = '0,
    parameter logic [11:0] FG_COLOR = 12'hFFF,
    parameter logic [11:0] BG_COLOR = 12'h000,
    localparam int SEL_W = $clog2(NUM_GLYPHS)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [SEL_W-1:0] sel,
    input  logic             inv,
    output logic             busy,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [11:0]      pix_data,
    output logic             pix_eol,
    output logic             pix_last,
    output logic             done
);

    localparam int TOT_BITS = NUM_GLYPHS * GLYPH_H * GLYPH_W;
    localparam int CW = $clog2(GLYPH_W);      // column counter width
    localparam int RW = $clog2(GLYPH_H);      // source row counter width
    localparam int SW = $clog2(SCALE + 1);    // repeat counter width (>=1)

    localparam logic [CW-1:0] COL_END = CW'(GLYPH_W - 1);
    localparam logic [RW-1:0] ROW_END = RW'(GLYPH_H - 1);
    localparam logic [SW-1:0] REP_END = SW'(SCALE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t state, state_nx;

    // Render context latched at start
    logic [SEL_W-1:0]   sel_q;
    logic               inv_q;

    // Datapath
    logic [GLYPH_W-1:0] shreg;   // current row, leftmost pixel in MSB
    logic [CW-1:0]      col;     // source column within the row
    logic [RW-1:0]      row;     // source row within the glyph
    logic [SW-1:0]      lrep;    // output line repeat of the current row
    logic [SW-1:0]      prep;    // horizontal repeat of the current bit

    logic               xfer;
    logic               bit_end;
    logic               line_end;
    logic               glyph_end;
    logic [SEL_W-1:0]   sel_ok;
    logic [GLYPH_W-1:0] row_bits;

    // Out-of-range glyph indices fall back to glyph 0. This is constant
    // false when NUM_GLYPHS is a power of two.
    assign sel_ok = (int'(sel) >= NUM_GLYPHS) ? '0 : sel;

    // Row lookup. Table index k = glyph*GLYPH_H + row, counted from the MSB end.
    always_comb begin
        int k;
        k        = int'(sel_q) * GLYPH_H + int'(row);
        row_bits = GLYPH_DATA[TOT_BITS - 1 - k * GLYPH_W -: GLYPH_W];
    end

    assign xfer      = (state == SHIFT) && pix_ready;
    assign bit_end   = (prep == REP_END);
    assign line_end  = bit_end && (col == COL_END);
    assign glyph_end = line_end && (lrep == REP_END) && (row == ROW_END);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = FETCH;
            FETCH:   state_nx = SHIFT;
            SHIFT:   if (xfer && line_end) state_nx = glyph_end ? FIN : FETCH;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ------------------------------------------------------------ datapath
    // Counters move only on an accepted transfer, so all pixel outputs stay
    // put while the consumer stalls. Each counter wraps to 0 at its terminal
    // value and never counts beyond it.
    always_ff @(posedge clk) begin
        if (clr) begin
            sel_q <= '0;
            inv_q <= 1'b0;
            shreg <= '0;
            col   <= '0;
            row   <= '0;
            lrep  <= '0;
            prep  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sel_q <= sel_ok;
                        inv_q <= inv;
                        col   <= '0;
                        row   <= '0;
                        lrep  <= '0;
                        prep  <= '0;
                    end
                end
                FETCH: begin
                    shreg <= row_bits;
                end
                SHIFT: begin
                    if (xfer) begin
                        if (!bit_end) begin
                            prep <= prep + SW'(1);
                        end else begin
                            prep  <= '0;
                            shreg <= {shreg[GLYPH_W-2:0], 1'b0};
                            if (col != COL_END) begin
                                col <= col + CW'(1);
                            end else begin
                                col <= '0;
                                // A repeated line re-fetches the same row.
                                // Otherwise advance to the next source row.
                                if (lrep != REP_END) begin
                                    lrep <= lrep + SW'(1);
                                end else begin
                                    lrep <= '0;
                                    row  <= (row == ROW_END) ? '0 : row + RW'(1);
                                end
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------- outputs
    // Pixel outputs are gated by SHIFT so that IDLE, FETCH and FIN, and the
    // state after a clear, present black with no flags.
    always_comb begin
        busy      = (state != IDLE);
        done      = (state == FIN);
        pix_valid = (state == SHIFT);
        pix_data  = 12'h000;
        pix_eol   = 1'b0;
        pix_last  = 1'b0;
        if (state == SHIFT) begin
            pix_data = (shreg[GLYPH_W-1] ^ inv_q) ? FG_COLOR : BG_COLOR;
            pix_eol  = line_end;
            pix_last = glyph_end;
        end
    end

endmodule

// File: tb/tb_glyph_stream.sv
// Scoreboard bench for glyph_stream. Instance 0 uses SCALE=1 and instance 1
// uses SCALE=2. Both use a 4x2 two-glyph font:
//   glyph0 = 1000 / 0001, glyph1 = 1111 / 0000.
// Stimulus pushes the hand-derived pixels {last,eol,data} into a
// per-instance queue. A negedge monitor pops the queue and compares on
// every transfer. It also checks timing: FETCH gap, done pulse, idle after
// FIN, start latency, stall hold, and the state after a clear.
module tb_glyph_stream;

    localparam logic [15:0] FONT = 16'b1000_0001_1111_0000;

    logic        clk = 1'b0;
    logic        clr;
    logic [1:0]  start, sel, inv, pix_ready;
    logic [1:0]  busy, pix_valid, pix_eol, pix_last, done;
    logic [11:0] pix_data [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        glyph_stream #(
            .GLYPH_W(4), .GLYPH_H(2), .NUM_GLYPHS(2), .SCALE(g + 1),
            .GLYPH_DATA(FONT), .FG_COLOR(12'hFFF), .BG_COLOR(12'h000)
        ) u_dut (
            .clk(clk), .clr(clr), .start(start[g]), .sel(sel[g:g]), .inv(inv[g]),
            .busy(busy[g]), .pix_valid(pix_valid[g]), .pix_ready(pix_ready[g]),
            .pix_data(pix_data[g]), .pix_eol(pix_eol[g]), .pix_last(pix_last[g]),
            .done(done[g])
        );
    end

    logic [13:0] q0 [$];
    logic [13:0] q1 [$];
    int vectors = 0, miscompares = 0, timeouts = 0;
    bit finish_req = 1'b0;

    // monitor state
    bit          pend_clr [2], armed [2], exp_done [2], exp_idle [2], exp_fetch [2], stall [2];
    int          lat [2];
    logic [13:0] held [2];

    task automatic chk(input int i, input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, i, $time, act, exp);
        end
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    task automatic mon(input int i);
        logic [13:0] cur, want;
        cur = {pix_last[i], pix_eol[i], pix_data[i]};
        if (pend_clr[i]) begin
            chk(i, "clr_state", {busy[i], pix_valid[i], done[i], cur}, 32'h0);
            armed[i] = 1'b1;
        end
        if (exp_done[i]) begin
            chk(i, "done_pulse", {done[i], pix_valid[i]}, 32'b10);
            exp_done[i] = 1'b0;
            exp_idle[i] = 1'b1;
        end else begin
            if (exp_idle[i]) begin
                chk(i, "idle_after_fin", busy[i], 32'h0);
                exp_idle[i] = 1'b0;
            end
            if (armed[i]) chk(i, "no_done", done[i], 32'h0);
        end
        if (exp_fetch[i]) begin
            chk(i, "fetch_gap", {pix_valid[i], busy[i]}, 32'b01);
            exp_fetch[i] = 1'b0;
        end
        if (lat[i] == 1) begin
            chk(i, "start_fetch", {pix_valid[i], busy[i]}, 32'b01);
            lat[i] = 2;
        end else if (lat[i] == 2) begin
            chk(i, "first_valid", pix_valid[i], 32'h1);
            lat[i] = 0;
        end
        if (stall[i] && pix_valid[i] === 1'b1) chk(i, "stall_hold", cur, held[i]);
        if (pix_valid[i] === 1'b1 && pix_ready[i]) begin
            if (qsize(i) == 0) begin
                chk(i, "sb_underflow", qsize(i), 32'h1);
            end else begin
                want = (i == 0) ? q0.pop_front() : q1.pop_front();
                chk(i, "pixel", cur, want);
                if (want[13]) exp_done[i] = 1'b1;
                else if (want[12]) exp_fetch[i] = 1'b1;
            end
        end
        stall[i] = (pix_valid[i] === 1'b1) && !pix_ready[i];
        held[i]  = cur;
        if (armed[i] && !clr && start[i] && busy[i] === 1'b0) lat[i] = 1;
        if (clr) begin
            exp_done[i] = 1'b0; exp_idle[i] = 1'b0; exp_fetch[i] = 1'b0;
            stall[i] = 1'b0; lat[i] = 0;
        end
        pend_clr[i] = clr;
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
        if (finish_req) begin
            chk(0, "sb_empty", q0.size(), 32'h0);
            chk(1, "sb_empty", q1.size(), 32'h0);
            chk(0, "timeouts", timeouts, 32'h0);
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic exp_px(input int i, input logic [11:0] d, input logic e, input logic l);
        if (i == 0) q0.push_back({l, e, d});
        else q1.push_back({l, e, d});
    endtask

    // 4x2 glyph at SCALE=1, given the 8 colours in order
    task automatic exp_glyph(input logic [11:0] c [8]);
        for (int p = 0; p < 8; p++) exp_px(0, c[p], (p % 4) == 3, p == 7);
    endtask

    task automatic do_start(input int i, input logic s, input logic v);
        @(posedge clk); #1;
        start[i] = 1'b1; sel[i] = s; inv[i] = v;
        @(posedge clk); #1;
        start[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (busy[i] === 1'b0 && qsize(i) == 0) return;
        end
        timeouts++;
        $display("FAIL wait_idle dut%0d: still busy after 600 cycles", i);
    endtask

    logic [11:0] glyph_a [8] = '{12'hFFF, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'hFFF};
    logic [11:0] glyph_b [8] = '{12'h000, 12'h000, 12'h000, 12'h000, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
    logic [11:0] glyph_c [8] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'h000};

    initial begin
        int n;
        clr = 1'b1; start = '0; sel = '0; inv = '0; pix_ready = 2'b11;
        repeat (3) @(posedge clk);
        #1 clr = 1'b0;
        repeat (2) @(posedge clk);

        // glyph 0, normal colours
        exp_glyph(glyph_a);
        do_start(0, 1'b0, 1'b0);
        wait_idle(0);

        // glyph 1, inverted
        exp_glyph(glyph_b);
        do_start(0, 1'b1, 1'b1);
        wait_idle(0);

        // glyph 0 with a randomly stalling consumer
        exp_glyph(glyph_a);
        do_start(0, 1'b0, 1'b0);
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            pix_ready[0] = 1'($urandom_range(0, 1));
            if (busy[0] === 1'b0 && q0.size() == 0) break;
        end
        pix_ready[0] = 1'b1;
        wait_idle(0);

        // SCALE=2: rows 1000 and 0001 doubled in both axes
        for (int ln = 0; ln < 4; ln++)
            for (int p = 0; p < 8; p++)
                exp_px(1, (ln < 2) ? ((p < 2) ? 12'hFFF : 12'h000) : ((p >= 6) ? 12'hFFF : 12'h000),
                       p == 7, (ln == 3) && (p == 7));
        do_start(1, 1'b0, 1'b0);
        wait_idle(1);

        // clear after 3 transfers, then a full render from row 0
        exp_glyph(glyph_a);
        do_start(0, 1'b0, 1'b0);
        n = 0;
        for (int c = 0; c < 100 && n < 3; c++) begin
            @(negedge clk);
            if (pix_valid[0] && pix_ready[0]) n++;
        end
        @(posedge clk); #1;
        clr = 1'b1; pix_ready[0] = 1'b0;
        q0.delete();
        @(posedge clk); #1;
        clr = 1'b0; pix_ready[0] = 1'b1;
        repeat (6) @(posedge clk);
        exp_glyph(glyph_a);
        do_start(0, 1'b0, 1'b0);
        wait_idle(0);

        // start held high: two back-to-back renders of glyph 1
        exp_glyph(glyph_c);
        exp_glyph(glyph_c);
        @(posedge clk); #1;
        start[0] = 1'b1; sel[0] = 1'b1; inv[0] = 1'b0;
        n = 0;
        for (int c = 0; c < 200 && n < 2; c++) begin
            @(negedge clk);
            if (done[0]) n++;
        end
        if (n < 2) begin
            timeouts++;
            $display("FAIL held_start dut0: saw %0d done pulses, expected 2", n);
        end
        @(posedge clk); #1;
        start[0] = 1'b0;
        wait_idle(0);

        repeat (3) @(posedge clk);
        finish_req = 1'b1;
    end

endmodule

// File: doc/glyph_stream.md
GLYPH_STREAM -- requirements
Module: glyph_stream

Interface
REQ-001 The block SHALL have parameter GLYPH_W, default 16, meaning glyph width in pixels (2..32).
REQ-002 The block SHALL have parameter GLYPH_H, default 16, meaning glyph height in rows (2..32).
REQ-003 The block SHALL have parameter NUM_GLYPHS, default 4, meaning number of stored glyphs (>=2).
REQ-004 The block SHALL have parameter SCALE, default 1, meaning pixel replication factor in both axes (1..4).
REQ-005 The block SHALL have parameter GLYPH_DATA, default all zeros, meaning a flat NUM_GLYPHS*GLYPH_H*GLYPH_W-bit table; glyph 0 row 0 occupies the most-significant GLYPH_W bits, then rows ascend, then glyphs ascend.
REQ-006 The block SHALL have parameters FG_COLOR, default 12'hFFF, and BG_COLOR, default 12'h000, meaning 4:4:4 RGB for set and clear bits.
REQ-007 The block SHALL have port clk, input, width 1: the single clock; all logic on its rising edge.
REQ-008 The block SHALL have port clr, input, width 1: synchronous, active-high reset.
REQ-009 The block SHALL have port start, input, width 1: request to render one glyph.
REQ-010 The block SHALL have port sel, input, width clog2(NUM_GLYPHS): glyph index, sampled with start.
REQ-011 The block SHALL have port inv, input, width 1: swap FG/BG, sampled with start.
REQ-012 The block SHALL have port busy, output, width 1: high from the cycle after an accepted start until done.
REQ-013 The block SHALL have port pix_valid, output, width 1: pix_data is valid.
REQ-014 The block SHALL have port pix_ready, input, width 1: downstream accepts a pixel.
REQ-015 The block SHALL have port pix_data, output, width 12: RGB pixel.
REQ-016 The block SHALL have port pix_eol, output, width 1: current pixel is the last of an output line.
REQ-017 The block SHALL have port pix_last, output, width 1: current pixel is the last of the glyph.
REQ-018 The block SHALL have port done, output, width 1: one-cycle pulse at completion.

Function
REQ-019 The FSM SHALL have states IDLE, FETCH, SHIFT, FIN.
REQ-020 In IDLE, start=1 SHALL latch sel and inv and enter FETCH; start in any other state SHALL be ignored.
REQ-021 sel >= NUM_GLYPHS SHALL be treated as sel = 0.
REQ-022 FETCH SHALL last exactly one cycle with pix_valid=0, loading the current source row into a GLYPH_W-bit shift register, then enter SHIFT.
REQ-023 First pix_valid SHALL therefore rise two cycles after the start cycle.
REQ-024 In SHIFT, pix_valid SHALL be 1; a pixel SHALL be transferred only when pix_valid and pix_ready are both 1.
REQ-025 While pix_valid=1 and pix_ready=0, pix_data, pix_eol and pix_last SHALL hold stable.
REQ-026 Row bits SHALL be emitted MSB first (MSB = leftmost); each bit SHALL be emitted SCALE consecutive times.
REQ-027 pix_data SHALL be FG_COLOR for bit=1 and BG_COLOR for bit=0, swapped when latched inv=1.
REQ-028 Each source row SHALL be emitted as SCALE consecutive output lines of GLYPH_W*SCALE pixels; every line, including repeats, SHALL be preceded by one FETCH cycle.
REQ-029 pix_eol SHALL be 1 on pixel GLYPH_W*SCALE-1 of each line; pix_last SHALL be 1 only on the final pixel of the final line.
REQ-030 Total transfers per glyph SHALL equal GLYPH_W*GLYPH_H*SCALE*SCALE.
REQ-031 The transfer of the pix_last pixel SHALL enter FIN; FIN SHALL assert done=1 for one cycle, with pix_valid=0, then return to IDLE.
REQ-032 busy SHALL be 1 in FETCH, SHIFT and FIN, and 0 in IDLE; start asserted in the FIN cycle SHALL be ignored, start in the following IDLE cycle accepted.
REQ-033 Row and column counters SHALL saturate-free wrap only via FSM control; no counter SHALL exceed its terminal value.

Reset
REQ-034 clr=1 SHALL, at the next rising edge, force IDLE and set busy, pix_valid, pix_eol, pix_last, done to 0 and pix_data to 12'h000, clearing all counters.
REQ-035 clr SHALL take priority over start and over an in-progress transfer; a glyph interrupted by clr SHALL not resume.

Verification
(Bench parameters: GLYPH_W=4, GLYPH_H=2, NUM_GLYPHS=2, SCALE=1; glyph0 rows 4'b1000, 4'b0001; glyph1 rows 4'b1111, 4'b0000.)
REQ-036 start, sel=0, inv=0, pix_ready=1 -> valid rises at cycle+2; pixels FFF,000,000,000 (eol on 4th), one idle FETCH cycle, then 000,000,000,FFF (eol+last on 4th), done pulses next cycle.
REQ-037 Same with inv=1, sel=1 -> 000,000,000,000 then FFF,FFF,FFF,FFF; 8 transfers total.
REQ-038 pix_ready toggled randomly -> pix_data/eol/last stable whenever valid=1 and ready=0; same 8-pixel sequence.
REQ-039 SCALE=2, sel=0 -> 4 lines of 8 pixels: FFF,FFF,000x6 twice, then 000x6,FFF,FFF twice; 32 transfers, last on 32nd.
REQ-040 clr asserted after 3 transfers -> next cycle busy=0, pix_valid=0, done never pulses; subsequent start renders the full glyph from row 0.
REQ-041 start held high continuously with sel=1 -> back-to-back glyphs, each preceded by one IDLE cycle after FIN; starts during busy ignored.
